lzc_normalizer: RTL

- Pipelined, parametrised leading-zero counter and normaliser for the range and low renormalisation path of the entropy encoder.
- Each accepted word produces three results:
  - its leading-zero count;
  - the word left-shifted by that count, so the MSB is set;
  - an all-zero flag.
- Input and output use valid/ready handshakes with full throughput.
- A running total of applied shifts is kept for the encoder's bit counter.

---
 rtl/lzc_normalizer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/lzc_normalizer.sv
// Leading-zero count + left-normalise, latency PIPE_STAGES (count in stage 1, shift in the last stage).
// Backpressure: a stage reloads only when empty or draining, so a stalled output holds and in_ready follows out_ready.
module lzc_normalizer #(
    parameter int RANGE_WIDTH = 16,
    parameter int D_SIZE      = 5,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RANGE_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [D_SIZE-1:0]      out_lzc,
    output logic [RANGE_WIDTH-1:0] out_norm,
    output logic                   out_zero,
    input  logic                   acc_clear,
    output logic [ACC_WIDTH-1:0]   acc_total
);

    if (RANGE_WIDTH < 2 || RANGE_WIDTH > 64) begin : g_bad_width
        $fatal(1, "lzc_normalizer: RANGE_WIDTH must be 2..64");
    end
    if (D_SIZE < $clog2(RANGE_WIDTH + 1)) begin : g_bad_dsize
        $fatal(1, "lzc_normalizer: D_SIZE too small for RANGE_WIDTH");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $fatal(1, "lzc_normalizer: PIPE_STAGES must be 1 or 2");
    end

    logic [D_SIZE-1:0]    in_lzc;
    logic                 in_zero;
    logic                 out_fire;
    logic [ACC_WIDTH-1:0] acc_q;

    // Ascending scan so the highest set bit is the last assignment and wins.
    always_comb begin
        in_lzc = D_SIZE'(RANGE_WIDTH);
        for (int i = 0; i < RANGE_WIDTH; i++) begin
            if (in_data[i]) begin
                in_lzc = D_SIZE'(RANGE_WIDTH - 1 - i);
            end
        end
    end

    assign in_zero = ~|in_data;

    if (PIPE_STAGES == 1) begin : g_one
        logic                   st_vld;
        logic [RANGE_WIDTH-1:0] st_norm;
        logic [D_SIZE-1:0]      st_lzc;
        logic                   st_zero;
        logic                   st_load;

        assign st_load  = !st_vld || out_ready;
        assign in_ready = st_load;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_vld  <= 1'b0;
                st_norm <= '0;
                st_lzc  <= '0;
                st_zero <= 1'b0;
            end else if (st_load) begin
                st_vld <= in_valid;
                if (in_valid) begin
                    st_norm <= in_data << in_lzc;
                    st_lzc  <= in_lzc;
                    st_zero <= in_zero;
                end
            end
        end

        assign out_valid = st_vld;
        assign out_norm  = st_norm;
        assign out_lzc   = st_lzc;
        assign out_zero  = st_zero;
    end else begin : g_two
        logic                   s1_vld;
        logic [RANGE_WIDTH-1:0] s1_dat;
        logic [D_SIZE-1:0]      s1_lzc;
        logic                   s1_zero;
        logic                   s1_load;
        logic                   s2_vld;
        logic [RANGE_WIDTH-1:0] s2_norm;
        logic [D_SIZE-1:0]      s2_lzc;
        logic                   s2_zero;
        logic                   s2_load;

        assign s2_load  = !s2_vld || out_ready;
        assign s1_load  = !s1_vld || s2_load;
        assign in_ready = s1_load;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1_vld  <= 1'b0;
                s1_dat  <= '0;
                s1_lzc  <= '0;
                s1_zero <= 1'b0;
            end else if (s1_load) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_dat  <= in_data;
                    s1_lzc  <= in_lzc;
                    s1_zero <= in_zero;
                end
            end
        end

        // Shift by RANGE_WIDTH for an all-zero word yields zero, so no special case.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s2_vld  <= 1'b0;
                s2_norm <= '0;
                s2_lzc  <= '0;
                s2_zero <= 1'b0;
            end else if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_norm <= s1_dat << s1_lzc;
                    s2_lzc  <= s1_lzc;
                    s2_zero <= s1_zero;
                end
            end
        end

        assign out_valid = s2_vld;
        assign out_norm  = s2_norm;
        assign out_lzc   = s2_lzc;
        assign out_zero  = s2_zero;
    end

    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else if (acc_clear) begin
            acc_q <= out_fire ? ACC_WIDTH'(out_lzc) : '0;
        end else if (out_fire) begin
            acc_q <= acc_q + ACC_WIDTH'(out_lzc);
        end
    end

    assign acc_total = acc_q;

endmodule
